instr_queue: RTL



---
 rtl/iq_pkg.sv | 22 ++
 rtl/instr_queue_if.sv | 31 +++
 rtl/iq_storage.sv | 32 +++
 rtl/instr_queue.sv | 121 ++++++++++++
 4 files changed

// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared constants, entry type and helpers for the instruction queue
package iq_pkg;
  localparam int INSTR_W      = 32;
  localparam int DEF_PC_WIDTH = 16;
  localparam int DEF_DEPTH    = 8;

  // One queue slot at the default PC width: {instr, pc, pred}
  typedef struct packed {
    logic [INSTR_W-1:0]      instr;
    logic [DEF_PC_WIDTH-1:0] pc;
    logic                    pred;
  } iq_entry_t;

  // Decode may ask for 3; the queue only ever hands out two per cycle
  function automatic logic [1:0] clamp_deq(input logic [1:0] d);
    return (d == 2'd3) ? 2'd2 : d;
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [1:0] b);
    return (a < b) ? a : b;
  endfunction
endpackage

// File: rtl/instr_queue_if.sv
// rtl/instr_queue_if.sv - fetch-side enqueue and decode-side dequeue bundle
interface instr_queue_if
  import iq_pkg::*;
#(
  parameter int PC_WIDTH = DEF_PC_WIDTH
);
  logic [1:0]          in_valid;
  logic [INSTR_W-1:0]  in_instr1;
  logic [INSTR_W-1:0]  in_instr2;
  logic [PC_WIDTH-1:0] in_pc;
  logic [1:0]          in_pred;
  logic                in_ready;
  logic [1:0]          out_valid;
  logic [INSTR_W-1:0]  out_instr1;
  logic [INSTR_W-1:0]  out_instr2;
  logic [PC_WIDTH-1:0] out_pc1;
  logic [PC_WIDTH-1:0] out_pc2;
  logic [1:0]          out_pred;
  logic [1:0]          deq_cnt;
  logic                flush;

  modport master (
    output in_valid, in_instr1, in_instr2, in_pc, in_pred, deq_cnt, flush,
    input  in_ready, out_valid, out_instr1, out_instr2, out_pc1, out_pc2, out_pred
  );

  modport slave (
    input  in_valid, in_instr1, in_instr2, in_pc, in_pred, deq_cnt, flush,
    output in_ready, out_valid, out_instr1, out_instr2, out_pc1, out_pc2, out_pred
  );
endinterface

// File: rtl/iq_storage.sv
// rtl/iq_storage.sv - 2-write/2-read entry array, contents never reset
module iq_storage
  import iq_pkg::*;
#(
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int PC_WIDTH = DEF_PC_WIDTH,
  localparam int AW       = $clog2(DEPTH),
  localparam int EW       = INSTR_W + PC_WIDTH + 1
) (
  input  logic          clk,
  input  logic          i_we0,
  input  logic          i_we1,
  input  logic [AW-1:0] i_waddr0,
  input  logic [AW-1:0] i_waddr1,
  input  logic [EW-1:0] i_wdata0,
  input  logic [EW-1:0] i_wdata1,
  input  logic [AW-1:0] i_raddr0,
  input  logic [AW-1:0] i_raddr1,
  output logic [EW-1:0] o_rdata0,
  output logic [EW-1:0] o_rdata1
);
  logic [EW-1:0] r_mem [DEPTH];

  // Write ports target distinct consecutive slots, so no collision handling is needed
  always_ff @(posedge clk) begin
    if (i_we0) r_mem[i_waddr0] <= i_wdata0;
    if (i_we1) r_mem[i_waddr1] <= i_wdata1;
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];
endmodule

// File: rtl/instr_queue.sv
// rtl/instr_queue.sv - 2-wide circular instruction queue; optional same-cycle bypass under IQ_BYPASS_EN
module instr_queue
  import iq_pkg::*;
#(
  parameter int DEPTH    = DEF_DEPTH,
  parameter int PC_WIDTH = DEF_PC_WIDTH
) (
  input logic          clk,
  input logic          reset_n,
  instr_queue_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INSTR_W + PC_WIDTH + 1;
  localparam logic [CW-1:0] LP_RDY_MAX = CW'(DEPTH - 2);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_in_ready;
  logic [1:0]    w_n_in;
  logic [1:0]    w_avail;
  logic [1:0]    w_deq_req;
  logic [1:0]    w_deq_stor;
  logic [1:0]    w_wr_n;
  logic [1:0]    w_out_valid;
  logic [EW-1:0] w_slot0;
  logic [EW-1:0] w_slot1;
  logic [EW-1:0] w_wdata0;
  logic [EW-1:0] w_rdata0;
  logic [EW-1:0] w_rdata1;
  logic [EW-1:0] w_out0;
  logic [EW-1:0] w_out1;

  // Ready looks only at registered count so fetch never sees a combinational loop
  assign w_in_ready = (r_count <= LP_RDY_MAX);
  assign w_slot0    = {bus.in_instr1, bus.in_pc, bus.in_pred[0]};
  assign w_slot1    = {bus.in_instr2, bus.in_pc + PC_WIDTH'(1), bus.in_pred[1]};
  assign w_avail    = (r_count >= CW'(2)) ? 2'd2 : r_count[1:0];
  assign w_deq_req  = clamp_deq(bus.deq_cnt);

  // Accepted slot count: 2'b10 is not a legal pattern and is dropped like a stall
  always_comb begin
    w_n_in = 2'd0;
    if (w_in_ready && !bus.flush) begin
      case (bus.in_valid)
        2'b01:   w_n_in = 2'd1;
        2'b11:   w_n_in = 2'd2;
        default: w_n_in = 2'd0;
      endcase
    end
  end

`ifdef IQ_BYPASS_EN
  logic [1:0] w_deq_byp;
  assign w_deq_byp = min2(w_deq_req, w_n_in);
`endif

  // Select pop/push amounts and what decode sees; bypass serves an empty queue straight from fetch
  always_comb begin
    w_deq_stor  = bus.flush ? 2'd0 : min2(w_deq_req, w_avail);
    w_wr_n      = w_n_in;
    w_out_valid = {r_count >= CW'(2), r_count != '0};
    w_out0      = w_rdata0;
    w_out1      = w_rdata1;
    w_wdata0    = w_slot0;
`ifdef IQ_BYPASS_EN
    if (r_count == '0 && !bus.flush) begin
      w_deq_stor  = 2'd0;
      w_wr_n      = w_n_in - w_deq_byp;
      w_out_valid = (w_n_in == 2'd2) ? 2'b11 : ((w_n_in == 2'd1) ? 2'b01 : 2'b00);
      w_out0      = w_slot0;
      w_out1      = w_slot1;
      w_wdata0    = (w_deq_byp == 2'd1) ? w_slot1 : w_slot0;
    end
`endif
  end

  // Pointer and occupancy update; reset beats flush, flush beats enqueue/dequeue
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + AW'(w_deq_stor);
      r_tail  <= r_tail + AW'(w_wr_n);
      r_count <= r_count + CW'(w_wr_n) - CW'(w_deq_stor);
    end
  end

  iq_storage #(
    .DEPTH    (DEPTH),
    .PC_WIDTH (PC_WIDTH)
  ) u_storage (
    .clk      (clk),
    .i_we0    (reset_n && (w_wr_n != 2'd0)),
    .i_we1    (reset_n && (w_wr_n == 2'd2)),
    .i_waddr0 (r_tail),
    .i_waddr1 (r_tail + AW'(1)),
    .i_wdata0 (w_wdata0),
    .i_wdata1 (w_slot1),
    .i_raddr0 (r_head),
    .i_raddr1 (r_head + AW'(1)),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1)
  );

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = w_out_valid;
  assign bus.out_instr1 = w_out0[EW-1 -: INSTR_W];
  assign bus.out_instr2 = w_out1[EW-1 -: INSTR_W];
  assign bus.out_pc1    = w_out0[PC_WIDTH:1];
  assign bus.out_pc2    = w_out1[PC_WIDTH:1];
  assign bus.out_pred   = {w_out1[0], w_out0[0]};
endmodule
